// File: rtl/hdr_pkg.sv
// Shared definitions for the HDR merge blocks: datapath widths, the hat
// weighting function, the merge FSM state type and default log exposure times.
package hdr_pkg;

    localparam int PIX_W  = 5;   // raw sample width
    localparam int G_W    = 8;   // camera response g(z) width
    localparam int DIFF_W = 10;  // g(z) - ln_dt, signed
    localparam int NUM_W  = 16;  // weighted numerator accumulator, signed
    localparam int DEN_W  = 6;   // weight-sum accumulator, unsigned (max 45)
    localparam int OUT_W  = 10;  // merged radiance, signed
    localparam int TERM_W = 14;  // w * diff, signed

    localparam logic signed [G_W-1:0] LN_DT0_DEF = -8'sd2;
    localparam logic signed [G_W-1:0] LN_DT1_DEF = 8'sd0;
    localparam logic signed [G_W-1:0] LN_DT2_DEF = 8'sd2;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        DIV   = 2'd2,
        DONE  = 2'd3
    } hdr_state_e;

    // Hat weight: rises 0..15 over the dark half, falls 15..0 over the bright half.
    function automatic logic [3:0] hat_w(input logic [PIX_W-1:0] z);
        logic [PIX_W-1:0] mirror;
        mirror = 5'd31 - z;
        return (z <= 5'd15) ? z[3:0] : mirror[3:0];
    endfunction

endpackage

// File: rtl/hdr_seq_div.sv
// Sequential restoring divider, unsigned NUM_W / DEN_W, one quotient bit per
// enabled cycle. start_i loads the operands; done_o pulses for one enabled
// cycle once all NUM_W bits are resolved, with the low OUT_W quotient bits on
// quotient_o. Shareable by the red/green/blue merge blocks.
//   clk_i, rst_i  clock, asynchronous active-high reset
//   en_i          clock enable; low freezes the divider
//   start_i       load dividend_i/divisor_i and begin
//   done_o        quotient_o valid this cycle
module hdr_seq_div
    import hdr_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             start_i,
    input  logic [NUM_W-1:0] dividend_i,
    input  logic [DEN_W-1:0] divisor_i,
    output logic             done_o,
    output logic [OUT_W-1:0] quotient_o
);

    logic [NUM_W-1:0] quo_q;   // dividend shifts out the top, quotient shifts in the bottom
    logic [DEN_W-1:0] rem_q;
    logic [DEN_W-1:0] dvs_q;
    logic [4:0]       cnt_q;
    logic             busy_q;

    logic [DEN_W:0]   rem_sh;
    logic [DEN_W:0]   rem_diff;
    logic             fits;

    // The remainder stays below the divisor, so the shifted remainder is below
    // twice the divisor and the trial difference's top bit is a clean borrow.
    assign rem_sh   = {rem_q, quo_q[NUM_W-1]};
    assign rem_diff = rem_sh - {1'b0, dvs_q};
    assign fits     = ~rem_diff[DEN_W];

    assign done_o     = busy_q && (cnt_q == 5'd0);
    assign quotient_o = quo_q[OUT_W-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (en_i) begin
            if (start_i) begin
                quo_q  <= dividend_i;
                rem_q  <= '0;
                dvs_q  <= divisor_i;
                cnt_q  <= 5'(NUM_W);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                if (cnt_q != 5'd0) begin
                    quo_q <= {quo_q[NUM_W-2:0], fits};
                    rem_q <= fits ? rem_diff[DEN_W-1:0] : rem_sh[DEN_W-1:0];
                    cnt_q <= cnt_q - 5'd1;
                end else begin
                    busy_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/hdr_blue_merge.sv
// Blue-channel HDR merge. Accepts three exposures of one pixel, looks each up
// in the camera-response LUT, and emits the Debevec weighted log radiance
//   sum w(z)(g(z) - ln_dt) / sum w(z)
// or, when every weight is zero, the exposure-1 difference as a fallback.
//   clk, rst             clock, asynchronous active-high reset
//   clk_en               global enable, low freezes everything
//   in_valid/in_ready    pixel input handshake, in_pixel exposures in order 0,1,2
//   lut_en/lut_pixel     LUT enable and address (address passes straight through)
//   lut_data             g(z), valid one enabled cycle after the address
//   out_valid/out_ready  result handshake; out_data signed, out_zero_w fallback flag
//
// state | meaning
// ACC   | accepting exposures, adding each term one cycle after its accept
// DRAIN | add the last term, capture sign and magnitude, launch the divide
// DIV   | wait for the divider (or bail out at once on zero weight)
// DONE  | hold the result until downstream takes it
module hdr_blue_merge
    import hdr_pkg::*;
#(
    parameter logic signed [G_W-1:0] LN_DT0 = LN_DT0_DEF,
    parameter logic signed [G_W-1:0] LN_DT1 = LN_DT1_DEF,
    parameter logic signed [G_W-1:0] LN_DT2 = LN_DT2_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             lut_en,
    output logic [PIX_W-1:0] lut_pixel,
    input  logic [G_W-1:0]   lut_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_zero_w
);

    hdr_state_e state_q, state_d;
    logic                     run_q;
    logic [1:0]               cnt_q, cnt_d;
    logic                     pend_q, pend_d;
    logic [1:0]               idx_q, idx_d;
    logic [PIX_W-1:0]         pix_q, pix_d;
    logic signed [NUM_W-1:0]  num_q, num_d;
    logic [DEN_W-1:0]         den_q, den_d;
    logic signed [DIFF_W-1:0] diff1_q, diff1_d;
    logic                     neg_q, neg_d;
    logic                     zero_q, zero_d;
    logic [OUT_W-1:0]         out_data_q, out_data_d;
    logic                     out_zero_q, out_zero_d;

    logic                     accept;
    logic signed [G_W-1:0]    ln_sel;
    logic [3:0]               w;
    logic signed [DIFF_W-1:0] diff;
    logic signed [TERM_W-1:0] term;
    logic signed [NUM_W-1:0]  num_add;
    logic [DEN_W-1:0]         den_add;
    logic [NUM_W-1:0]         mag;
    logic                     div_start;
    logic                     div_done;
    logic [OUT_W-1:0]         div_quo;

    assign in_ready   = run_q && (state_q == ACC);
    assign accept     = clk_en && in_valid && in_ready;
    assign lut_en     = clk_en && !rst;
    assign lut_pixel  = rst ? '0 : in_pixel;
    assign out_valid  = (state_q == DONE);
    assign out_data   = out_data_q;
    assign out_zero_w = out_zero_q;

    // Term for the exposure accepted on the previous enabled edge; the LUT
    // output and the delayed pixel line up during this cycle.
    always_comb begin
        case (idx_q)
            2'd0:    ln_sel = LN_DT0;
            2'd1:    ln_sel = LN_DT1;
            default: ln_sel = LN_DT2;
        endcase
    end

    assign w       = hat_w(pix_q);
    assign diff    = $signed({2'b00, lut_data}) - $signed({{2{ln_sel[G_W-1]}}, ln_sel});
    assign term    = $signed({10'b0, w}) * $signed({{4{diff[DIFF_W-1]}}, diff});
    assign num_add = pend_q ? num_q + $signed({{2{term[TERM_W-1]}}, term}) : num_q;
    assign den_add = pend_q ? den_q + {2'b00, w} : den_q;
    assign mag     = num_add[NUM_W-1] ? NUM_W'(-num_add) : num_add;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = accept;
        idx_d      = idx_q;
        pix_d      = pix_q;
        num_d      = num_add;
        den_d      = den_add;
        diff1_d    = diff1_q;
        neg_d      = neg_q;
        zero_d     = zero_q;
        out_data_d = out_data_q;
        out_zero_d = out_zero_q;
        div_start  = 1'b0;

        if (accept) begin
            pix_d = in_pixel;
            idx_d = cnt_q;
        end
        if (pend_q && (idx_q == 2'd1)) begin
            diff1_d = diff;
        end

        case (state_q)
            ACC: begin
                if (accept) begin
                    if (cnt_q == 2'd2) begin
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            DRAIN: begin
                neg_d     = num_add[NUM_W-1];
                zero_d    = (den_add == '0);
                div_start = (den_add != '0);
                state_d   = DIV;
            end
            DIV: begin
                if (zero_q) begin
                    out_data_d = diff1_q;
                    out_zero_d = 1'b1;
                    state_d    = DONE;
                end else if (div_done) begin
                    out_data_d = neg_q ? OUT_W'(-div_quo) : div_quo;
                    out_zero_d = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    num_d   = '0;
                    den_d   = '0;
                    cnt_d   = '0;
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ACC;
            run_q      <= 1'b0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            idx_q      <= '0;
            pix_q      <= '0;
            num_q      <= '0;
            den_q      <= '0;
            diff1_q    <= '0;
            neg_q      <= 1'b0;
            zero_q     <= 1'b0;
            out_data_q <= '0;
            out_zero_q <= 1'b0;
        end else if (clk_en) begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            idx_q      <= idx_d;
            pix_q      <= pix_d;
            num_q      <= num_d;
            den_q      <= den_d;
            diff1_q    <= diff1_d;
            neg_q      <= neg_d;
            zero_q     <= zero_d;
            out_data_q <= out_data_d;
            out_zero_q <= out_zero_d;
        end
    end

    hdr_seq_div u_div (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (clk_en),
        .start_i    (div_start),
        .dividend_i (mag),
        .divisor_i  (den_add),
        .done_o     (div_done),
        .quotient_o (div_quo)
    );

endmodule

// File: doc/hdr_blue_merge.md
Name: hdr_blue_merge

Overview:
- Downstream consumer of the blue-channel camera-response LUT (5-bit pixel in, 8-bit g(z) out, one-cycle registered latency, clk_en gated).
- Takes three exposures of the same blue pixel in sequence and drives the LUT address.
- Forms the Debevec weighted log-radiance: sum w(z)(g(z) - ln_dt) / sum w(z).
- Emits one signed radiance value per pixel triplet to the tone-mapping stage over a valid/ready handshake.

Parameters:
- LN_DT0, -2, signed 8-bit log exposure time of exposure 0 (same units as g)
- LN_DT1, 0, signed 8-bit log exposure time of exposure 1
- LN_DT2, 2, signed 8-bit log exposure time of exposure 2

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- clk_en  in  1  global enable; low freezes all state and outputs
- in_valid  in  1  pixel available
- in_ready  out  1  block accepts pixel this cycle
- in_pixel  in  5  raw blue sample, exposures presented in order 0,1,2
- lut_en  out  1  LUT clock enable
- lut_pixel  out  5  LUT address
- lut_data  in  8  g(z) from LUT, valid one enabled cycle after address
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_data  out  10  signed radiance, two's complement
- out_zero_w  out  1  result came from the zero-weight fallback

Behaviour:
- Reset: in_ready=0, lut_en=0, lut_pixel=0, out_valid=0, out_data=0, out_zero_w=0, accumulators=0, exposure counter=0, state=ACC. in_ready=1 from the first enabled cycle after reset release.
- Timing: all transitions occur only on clk edges with clk_en=1. lut_en = clk_en. lut_pixel = in_pixel (combinational pass-through), so the LUT samples on the accept edge.
- Weight: w(z) = z<=15 ? z : 31-z, 4-bit unsigned, range 0..15. in_pixel is delayed one cycle to align with lut_data.
- Arithmetic:
  - diff = {2'b0,g} - sext(LN_DT[k]), signed 10-bit.
  - term = w*diff, signed 14-bit.
  - num accumulates as signed 16-bit; den accumulates as unsigned 6-bit (max 45).
  - The diff of exposure 1 is stored for the fallback.
- FSM:
  - ACC: in_ready=1. Each accept increments the exposure counter 0→1→2. The term for the previous accept is added the following enabled cycle. Accepting exposure 2 goes to DRAIN.
  - DRAIN: in_ready=0, one cycle; adds the last term and captures sign and magnitude of num. If den=0, go to DONE with out_data = exposure-1 diff and out_zero_w=1. Otherwise go to DIV.
  - DIV: 16 cycles of restoring division |num|/den, quotient truncated toward zero. Result is negated if num<0, then go to DONE with out_zero_w=0.
  - DONE: out_valid=1. out_data and out_zero_w are held stable until out_valid&out_ready. On that edge, clear num, den and the counter, drop out_valid, and return to ACC. in_ready stays 0 throughout DONE.
- Latency: out_valid rises exactly 18 enabled edges after the edge that accepted exposure 2 (DRAIN 1 + DIV 16 + 1). The zero-weight fallback takes 2 edges.
- Range: |quotient| ≤ 383 fits out_data; no saturation required.
- Idle input: in_valid low while in ACC leaves the counter and accumulators unchanged. There is no timeout.
- Reset mid-operation (any state): immediate return to reset values. A partial triplet is discarded.
- clk_en low for any number of cycles in any state: no state change; latency counts only enabled edges.

Decomposition:
- hdr_pkg holds:
  - width constants: PIX_W=5, G_W=8, DIFF_W=10, NUM_W=16, DEN_W=6, OUT_W=10
  - a weight function hat_w(z)
  - state enum ACC/DRAIN/DIV/DONE
  - default LN_DT values
- One sub-module, hdr_seq_div: start/done unsigned 16/6 restoring divider, one bit per enabled cycle, shareable by the red and green merge blocks.

Test Plan:
- Basic merge: pixels 8,16,24 (g=13,13,19). Weights 8,15,7; num=434, den=30 → out_data=14, out_zero_w=0, out_valid 18 edges after the third accept.
- Zero weight: pixels 0,31,0 → den=0 → out_data=27 (g(31)-LN_DT1), out_zero_w=1, 2-edge latency.
- Negative result: pixels 31,31,1 (g(1)=0) → num=-2, den=1 → out_data=10'h3FE (-2).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_valid and out_data stable, in_ready=0. The next triplet is accepted only after the handshake.
- clk_en and gaps:
  - Deassert clk_en 4 cycles mid-DIV and insert in_valid gaps between exposures → same 14 result for 8,16,24.
  - out_valid arrives 18 enabled edges after the last accept.
- Reset mid-DIV: assert rst → all outputs 0 immediately. A following 8,16,24 triplet yields 14.
